// File: rtl/transaction_vc_arbiter.sv
// Transaction-layer core: sorts ingress words by class into per-class FIFOs and
// drains them through a round-robin or strict-priority arbiter into one registered egress stream.
module transaction_vc_arbiter #(
  parameter int DATA_W    = 12,
  parameter int NUM_VC    = 4,
  parameter int DEPTH     = 8,
  parameter int CLASS_LSB = 10,
  parameter int CNT_W     = 5,
  parameter int ARB_MODE  = 0,
  localparam int CW = $clog2(NUM_VC),
  localparam int OW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [OW-1:0]     umbral_alto,
  input  logic [OW-1:0]     umbral_bajo,
  input  logic              push_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_out,
  output logic [NUM_VC-1:0] almost_full,
  output logic [NUM_VC-1:0] almost_empty,
  output logic              drop_err,
  input  logic              req,
  input  logic [CW:0]       idx,
  output logic [CNT_W-1:0]  count_out,
  output logic              count_valid,
  output logic [1:0]        state
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   NUM_VC_IDX = (CW+1)'(NUM_VC);
  localparam logic [OW-1:0] FULL_OCC   = OW'(DEPTH);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [OW-1:0]       occ_q    [NUM_VC];
  logic [OW-1:0]       occ_d    [NUM_VC];
  logic [PW-1:0]       wr_ptr_q [NUM_VC];
  logic [PW-1:0]       wr_ptr_d [NUM_VC];
  logic [PW-1:0]       rd_ptr_q [NUM_VC];
  logic [PW-1:0]       rd_ptr_d [NUM_VC];
  logic [CNT_W-1:0]    cnt_q    [NUM_VC];
  logic [CNT_W-1:0]    cnt_d    [NUM_VC];
  logic [DATA_W-1:0]   mem_q    [NUM_VC][DEPTH];

  logic [OW-1:0]       alto_q, alto_d, bajo_q, bajo_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic [CW-1:0]       rr_q, rr_d;
  logic [NUM_VC-1:0]   af_q, af_d, ae_q, ae_d;
  logic                drop_q, drop_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                count_valid_q, count_valid_d;

  logic [CW-1:0]       tgt, grant, cand, cls_out;
  logic                grant_vld, push_ok, accept_state, load, pop, any_nonempty;
  logic [NUM_VC-1:0]   push_vec, pop_vec, nonempty;

  assign tgt          = data_in[CLASS_LSB +: CW];
  assign cls_out      = data_q[CLASS_LSB +: CW];
  assign accept_state = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
  // A full FIFO drops the word even if it is popped this cycle.
  assign push_ok      = push_in && accept_state && (occ_q[tgt] != FULL_OCC);
  assign load         = !valid_q || ready_out;
  assign pop          = load && grant_vld;
  assign any_nonempty = |nonempty;

  // Arbiter: RR searches upward from rr_q; strict always starts at class 0.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand      = '0;
    nonempty  = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      nonempty[i] = (occ_q[i] != '0);
      cand = (ARB_MODE == 1) ? CW'(i) : rr_q + CW'(i);
      if (!grant_vld && occ_q[cand] != '0) begin
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
  end

  // NOTE: combinational blocks use blocking '='; only the flop block uses '<='.
  always_comb begin
    push_vec = '0;
    pop_vec  = '0;
    af_d     = '0;
    ae_d     = '0;
    for (int c = 0; c < NUM_VC; c++) begin
      push_vec[c] = push_ok && (tgt == CW'(c));
      pop_vec[c]  = pop && (grant == CW'(c));
      wr_ptr_d[c] = push_vec[c] ? wr_ptr_q[c] + PW'(1) : wr_ptr_q[c];
      rd_ptr_d[c] = pop_vec[c]  ? rd_ptr_q[c] + PW'(1) : rd_ptr_q[c];
      case ({push_vec[c], pop_vec[c]})
        2'b10:   occ_d[c] = occ_q[c] + OW'(1);
        2'b01:   occ_d[c] = occ_q[c] - OW'(1);
        default: occ_d[c] = occ_q[c];
      endcase
      af_d[c] = (occ_d[c] >= alto_q);
      ae_d[c] = (occ_d[c] <= bajo_q);
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    rr_d    = rr_q;
    if (load) begin
      valid_d = grant_vld;
      if (grant_vld) begin
        data_d = mem_q[grant][rd_ptr_q[grant]];
        rr_d   = grant + CW'(1);
      end
    end
  end

  // Reads sample cnt_q, so a same-cycle increment is not yet visible.
  always_comb begin
    for (int c = 0; c < NUM_VC; c++) cnt_d[c] = cnt_q[c];
    if (valid_q && ready_out) cnt_d[cls_out] = cnt_q[cls_out] + CNT_W'(1);
    count_valid_d = req && (state_q == ST_IDLE);
    count_d       = count_q;
    if (count_valid_d) count_d = (idx < NUM_VC_IDX) ? cnt_q[idx[CW-1:0]] : '0;
    drop_d = push_in && !push_ok;
    alto_d = (state_q == ST_INIT) ? umbral_alto : alto_q;
    bajo_d = (state_q == ST_INIT) ? umbral_bajo : bajo_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)                         state_d = ST_INIT;
        else if (any_nonempty || push_ok) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: if (!any_nonempty && !push_ok && !valid_q) state_d = ST_IDLE;
      default:   state_d = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RESET;
      alto_q        <= '0;
      bajo_q        <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      rr_q          <= '0;
      af_q          <= '0;
      ae_q          <= '0;
      drop_q        <= 1'b0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      for (int c = 0; c < NUM_VC; c++) begin
        occ_q[c]    <= '0;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
    end else begin
      state_q       <= state_d;
      alto_q        <= alto_d;
      bajo_q        <= bajo_d;
      data_q        <= data_d;
      valid_q       <= valid_d;
      rr_q          <= rr_d;
      af_q          <= af_d;
      ae_q          <= ae_d;
      drop_q        <= drop_d;
      count_q       <= count_d;
      count_valid_q <= count_valid_d;
      for (int c = 0; c < NUM_VC; c++) begin
        occ_q[c]    <= occ_d[c];
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
      end
    end
  end

  // NOTE: the storage array has no reset; occupancy and pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[tgt][wr_ptr_q[tgt]] <= data_in;
  end

  assign data_out     = data_q;
  assign valid_out    = valid_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign drop_err     = drop_q;
  assign count_out    = count_q;
  assign count_valid  = count_valid_q;
  assign state        = state_q;

endmodule

// File: tb/tb_transaction_vc_arbiter.sv
// Directed bench for transaction_vc_arbiter: a round-robin and a strict-priority
// instance share stimulus; expected values are hand-computed constants.
module tb_transaction_vc_arbiter;

  localparam int DATA_W = 12;
  localparam int NUM_VC = 4;
  localparam int CNT_W  = 5;
  localparam int CW     = 2;
  localparam int OW     = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1, init = 1'b0, push_in = 1'b0, ready_out = 1'b0, req = 1'b0;
  logic [OW-1:0]     umbral_alto = '0, umbral_bajo = '0;
  logic [DATA_W-1:0] data_in = '0;
  logic [CW:0]       idx = '0;

  logic [DATA_W-1:0] dout_rr, dout_sp;
  logic              valid_rr, valid_sp, drop_rr, drop_sp, cv_rr, cv_sp;
  logic [NUM_VC-1:0] af_rr, af_sp, ae_rr, ae_sp;
  logic [CNT_W-1:0]  cnt_rr, cnt_sp;
  logic [1:0]        st_rr, st_sp;

  transaction_vc_arbiter #(.ARB_MODE(0)) dut_rr (
    .clk(clk), .reset(reset), .init(init), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .push_in(push_in), .data_in(data_in), .data_out(dout_rr), .valid_out(valid_rr),
    .ready_out(ready_out), .almost_full(af_rr), .almost_empty(ae_rr), .drop_err(drop_rr),
    .req(req), .idx(idx), .count_out(cnt_rr), .count_valid(cv_rr), .state(st_rr));

  transaction_vc_arbiter #(.ARB_MODE(1)) dut_sp (
    .clk(clk), .reset(reset), .init(init), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .push_in(push_in), .data_in(data_in), .data_out(dout_sp), .valid_out(valid_sp),
    .ready_out(ready_out), .almost_full(af_sp), .almost_empty(ae_sp), .drop_err(drop_sp),
    .req(req), .idx(idx), .count_out(cnt_sp), .count_valid(cv_sp), .state(st_sp));

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] q_rr[$];
  logic [DATA_W-1:0] q_sp[$];

  logic [DATA_W-1:0] exp_t3[9]    = '{12'h000, 12'h400, 12'h401, 12'h402, 12'h403,
                                      12'h404, 12'h405, 12'h406, 12'h407};
  logic [DATA_W-1:0] load_t4[8]   = '{12'h001, 12'h002, 12'h401, 12'h402,
                                      12'h801, 12'h802, 12'hC01, 12'hC02};
  logic [DATA_W-1:0] exp_t4_rr[8] = '{12'h001, 12'h401, 12'h801, 12'hC01,
                                      12'h002, 12'h402, 12'h802, 12'hC02};
  logic [DATA_W-1:0] exp_t4_sp[8] = '{12'h001, 12'h002, 12'h401, 12'h402,
                                      12'h801, 12'h802, 12'hC01, 12'hC02};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input string tag);
    reset = 1'b1; init = 1'b0; push_in = 1'b0; req = 1'b0;
    tick(); tick();
    reset = 1'b0; init = 1'b1; umbral_alto = 4'd6; umbral_bajo = 4'd1;
    tick(); tick();
    init = 1'b0;
    tick();
    check(tag, st_rr, 2);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && st_rr != 2'd2; i++) tick();
    check(tag, st_rr, 2);
  endtask

  task automatic collect(input int cycles);
    q_rr.delete();
    q_sp.delete();
    for (int i = 0; i < cycles; i++) begin
      if (valid_rr) q_rr.push_back(dout_rr);
      if (valid_sp) q_sp.push_back(dout_sp);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values and threshold latching.
    #1;
    tick(); tick();
    check("t1_state_reset", st_rr, 0);
    check("t1_valid", valid_rr, 0);
    check("t1_data", dout_rr, 0);
    check("t1_drop", drop_rr, 0);
    check("t1_cv", cv_rr, 0);
    check("t1_cnt", cnt_rr, 0);
    check("t1_af", af_rr, 0);
    check("t1_ae", ae_rr, 0);
    reset = 1'b0; init = 1'b1; umbral_alto = 4'd6; umbral_bajo = 4'd1;
    tick();
    check("t1_state_init0", st_rr, 1);
    tick();
    check("t1_state_init1", st_rr, 1);
    init = 1'b0;
    tick();
    check("t1_state_idle", st_rr, 2);
    check("t1_af_idle", af_rr, 4'h0);
    check("t1_ae_idle", ae_rr, 4'hF);
    check("t1_valid_idle", valid_rr, 0);

    // One word per class, two-edge latency, arrival order preserved.
    ready_out = 1'b1; push_in = 1'b1; data_in = 12'h000;
    tick();
    check("t2_lat_edge1", valid_rr, 0);
    check("t2_active", st_rr, 3);
    data_in = 12'h400;
    tick();
    check("t2_v0", valid_rr, 1);
    check("t2_d0", dout_rr, 12'h000);
    data_in = 12'h800;
    tick();
    check("t2_d1", dout_rr, 12'h400);
    data_in = 12'hC00;
    tick();
    check("t2_d2", dout_rr, 12'h800);
    check("t2_d2_sp", dout_sp, 12'h800);
    push_in = 1'b0;
    tick();
    check("t2_v3", valid_rr, 1);
    check("t2_d3", dout_rr, 12'hC00);
    tick();
    check("t2_drained", valid_rr, 0);
    check("t2_still_active", st_rr, 3);
    tick();
    check("t2_back_idle", st_rr, 2);
    check("t2_drop", drop_rr, 0);

    // Backpressure: a class-0 word parks in the egress register, class 1 overflows.
    ready_out = 1'b0; push_in = 1'b1; data_in = 12'h000;
    tick();
    for (int k = 0; k < 9; k++) begin
      data_in = 12'h400 + 12'(k);
      tick();
      check($sformatf("t3_af_%0d", k), af_rr[1], (k >= 5) ? 1 : 0);
      check($sformatf("t3_ae_%0d", k), ae_rr[1], (k == 0) ? 1 : 0);
      check($sformatf("t3_drop_%0d", k), drop_rr, (k == 8) ? 1 : 0);
    end
    check("t3_hold_valid", valid_rr, 1);
    check("t3_hold_data", dout_rr, 12'h000);
    push_in = 1'b0; ready_out = 1'b1;
    collect(16);
    check("t3_count", q_rr.size(), 9);
    for (int i = 0; i < 9; i++)
      check($sformatf("t3_word_%0d", i), (i < q_rr.size()) ? 32'(q_rr[i]) : 32'hDEAD, exp_t3[i]);
    check("t3_drop_clear", drop_rr, 0);
    wait_idle("t3_idle");

    // Arbitration order with two words per class queued behind a stalled egress.
    ready_out = 1'b0; push_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_in = load_t4[i];
      tick();
    end
    push_in = 1'b0; ready_out = 1'b1;
    collect(14);
    check("t4_rr_count", q_rr.size(), 8);
    check("t4_sp_count", q_sp.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_rr_%0d", i), (i < q_rr.size()) ? 32'(q_rr[i]) : 32'hDEAD, exp_t4_rr[i]);
      check($sformatf("t4_sp_%0d", i), (i < q_sp.size()) ? 32'(q_sp[i]) : 32'hDEAD, exp_t4_sp[i]);
    end
    wait_idle("t4_idle");

    // Counter wrap: 33 class-2 words from a fresh reset leave cnt[2] = 1.
    do_init("t5_init");
    ready_out = 1'b1; idx = 3'd2;
    for (int i = 0; i < 33; i++) begin
      push_in = 1'b1; data_in = 12'h800 + 12'(i);
      req = (i >= 1);
      tick();
      if (i == 2) check("t5_req_active", cv_rr, 0);
    end
    push_in = 1'b0; req = 1'b0;
    wait_idle("t5_idle");
    req = 1'b1; idx = 3'd2;
    tick();
    check("t5_cv", cv_rr, 1);
    check("t5_cnt2", cnt_rr, 1);
    check("t5_cnt2_sp", cnt_sp, 1);
    idx = 3'd5;
    tick();
    check("t5_cv_oob", cv_rr, 1);
    check("t5_cnt_oob", cnt_rr, 0);
    req = 1'b0;
    tick();
    check("t5_cv_off", cv_rr, 0);

    // Reset mid-stream discards queued words and clears counters.
    ready_out = 1'b0; push_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = 12'hC05 + 12'(i);
      tick();
    end
    check("t6_pre_valid", valid_rr, 1);
    push_in = 1'b0; reset = 1'b1;
    tick();
    check("t6_valid", valid_rr, 0);
    check("t6_state", st_rr, 0);
    check("t6_data", dout_rr, 0);
    do_init("t6_init");
    ready_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_empty_%0d", i), valid_rr, 0);
      check($sformatf("t6_idle_%0d", i), st_rr, 2);
    end
    check("t6_ae", ae_rr, 4'hF);
    req = 1'b1; idx = 3'd2;
    tick();
    check("t6_cnt2", cnt_rr, 0);
    idx = 3'd3;
    tick();
    check("t6_cnt3", cnt_rr, 0);
    check("t6_cv", cv_rr, 1);
    req = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
